// File: rtl/alu_word_sequencer_if.sv
// Request/response handshake bundle between a requesting master and the word sequencer.
// The master drives operands and opcode, and the sequencer returns the assembled result with its flags.
interface alu_word_sequencer_if #(
   parameter int WIDTH = 16
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_cin;
   logic [3:0]       req_op;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_result;
   logic             resp_cout;
   logic             resp_ovf;
   logic             resp_zero;
   logic             resp_err;

   modport master (
      output req_valid, req_a, req_b, req_cin, req_op, resp_ready,
      input  req_ready, resp_valid, resp_result, resp_cout, resp_ovf, resp_zero, resp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, req_op, resp_ready,
      output req_ready, resp_valid, resp_result, resp_cout, resp_ovf, resp_zero, resp_err
   );
endinterface

// File: rtl/alu_word_sequencer.sv
// Runs WIDTH-bit operations through one external 4-bit combinational ALU, one nibble per cycle, LSB first.
// Adder-class opcodes chain carry between nibbles, and logic-class opcodes treat each nibble independently.
module alu_word_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   alu_word_sequencer_if.slave  bus,
   output logic [3:0]           o_alu_a,
   output logic [3:0]           o_alu_b,
   output logic                 o_alu_cin,
   output logic [3:0]           o_alu_s,
   input  logic [3:0]           i_alu_result,
   input  logic                 i_alu_cout,
   input  logic                 i_alu_overflow
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [3:0]       r_op;
   logic             r_cin;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             r_err;

   logic             w_reqAdder;
   logic             w_reqLogic;
   logic             w_opAdder;
   logic             w_lastNib;
   logic [IW+1:0]    w_bitBase;

   function automatic logic isAdder(input logic [3:0] op);
      return (op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111});
   endfunction

   assign w_reqAdder = isAdder(bus.req_op);
   assign w_reqLogic = bus.req_op[3];
   assign w_opAdder  = isAdder(r_op);
   assign w_lastNib  = (r_idx == IW'(NIB - 1));
   assign w_bitBase  = {r_idx, 2'b00};

   assign bus.req_ready   = (r_state == IDLE);
   assign bus.resp_valid  = (r_state == DONE);
   assign bus.resp_result = r_res;
   assign bus.resp_cout   = r_cout;
   assign bus.resp_ovf    = r_ovf;
   assign bus.resp_err    = r_err;
   assign bus.resp_zero   = (r_state == DONE) && (r_res == '0);

   // The ALU sees live operands only while a pass is in flight, and idles at zero otherwise.
   always_comb begin
      o_alu_a   = 4'h0;
      o_alu_b   = 4'h0;
      o_alu_cin = 1'b0;
      o_alu_s   = 4'h0;
      if (r_state == RUN) begin
         o_alu_a   = r_a[w_bitBase +: 4];
         o_alu_b   = r_b[w_bitBase +: 4];
         o_alu_s   = r_op;
         o_alu_cin = w_opAdder ? ((r_idx == '0) ? r_cin : r_carry) : 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_op    <= 4'h0;
         r_cin   <= 1'b0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_a     <= bus.req_a;
                  r_b     <= bus.req_b;
                  r_cin   <= bus.req_cin;
                  r_op    <= bus.req_op;
                  r_res   <= '0;
                  r_carry <= 1'b0;
                  r_cout  <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_idx   <= '0;
                  // Unsupported opcodes skip the ALU entirely and report an error with a zero result.
                  if (w_reqAdder || w_reqLogic) begin
                     r_err   <= 1'b0;
                     r_state <= RUN;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end
            RUN: begin
               r_res[w_bitBase +: 4] <= i_alu_result;
               r_carry               <= i_alu_cout;
               if (w_lastNib) begin
                  r_cout  <= w_opAdder & i_alu_cout;
                  r_ovf   <= w_opAdder & i_alu_overflow;
                  r_idx   <= '0;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               if (bus.resp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer with a behavioural 4-bit ALU hooked to its ALU port.
// A table of word operations is checked first, followed by backpressure and mid-operation reset sequences.
module tb_alu_word_sequencer;
   localparam int WIDTH = 16;
   localparam int NIB   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_word_sequencer_if #(.WIDTH(WIDTH)) bus ();

   logic [3:0] aluA, aluB, aluS, aluRes;
   logic       aluCin, aluCout, aluOvf;

   alu_word_sequencer #(.WIDTH(WIDTH)) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .bus            (bus),
      .o_alu_a        (aluA),
      .o_alu_b        (aluB),
      .o_alu_cin      (aluCin),
      .o_alu_s        (aluS),
      .i_alu_result   (aluRes),
      .i_alu_cout     (aluCout),
      .i_alu_overflow (aluOvf)
   );

   // ALU model: add, A+~B, A+0, A+F and A+A are the adder ops, and 8-F are logic ops.
   // Logic ops raise a stray Cout on purpose so that masking in the sequencer is visible.
   logic [3:0] aluY;
   logic [4:0] aluSum;
   always_comb begin
      aluY    = aluB;
      aluSum  = 5'd0;
      aluRes  = 4'h0;
      aluCout = 1'b0;
      aluOvf  = 1'b0;
      case (aluS)
         4'b0001: aluY = ~aluB;
         4'b0010: aluY = 4'h0;
         4'b0011: aluY = 4'hF;
         4'b0111: aluY = aluA;
         default: aluY = aluB;
      endcase
      if (aluS inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111}) begin
         aluSum  = {1'b0, aluA} + {1'b0, aluY} + {4'b0, aluCin};
         aluRes  = aluSum[3:0];
         aluCout = aluSum[4];
         aluOvf  = (aluA[3] == aluY[3]) && (aluSum[3] != aluA[3]);
      end else if (aluS[3]) begin
         aluCout = 1'b1;
         case (aluS[2:0])
            3'd0: aluRes = aluA & aluB;
            3'd1: aluRes = aluA | aluB;
            3'd2: aluRes = aluA ^ aluB;
            3'd3: aluRes = ~(aluA & aluB);
            3'd4: aluRes = ~(aluA | aluB);
            3'd5: aluRes = ~(aluA ^ aluB);
            3'd6: aluRes = ~aluA;
            default: aluRes = aluA;
         endcase
      end
   end

   int nVectors     = 0;
   int nMiscompares = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
      end
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [3:0]  op;
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        err;
      int          lat;
      logic [3:0]  cinVec;
   } vec_t;

   vec_t vecs[11];

   logic [3:0] cinSeen;
   int         latSeen;
   logic       sBad;

   // Accept one request, then record alu_cin per pass and the number of edges after the accept edge until resp_valid.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic [3:0] op);
      int guard;
      logic [3:0] expS;
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      checkOutput("req_ready before accept", {31'b0, bus.req_ready}, 32'd1);
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_cin   = cin;
      bus.req_op    = op;
      bus.req_valid = 1'b1;
      checkOutput("alu_s idle", {28'b0, aluS}, 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      expS    = (op inside {4'b0100, 4'b0101, 4'b0110}) ? 4'h0 : op;
      cinSeen = 4'h0;
      sBad    = 1'b0;
      latSeen = 0;
      while (!bus.resp_valid && latSeen < 20) begin
         if (latSeen < NIB) cinSeen[latSeen[1:0]] = aluCin;
         if (aluS !== expS) sBad = 1'b1;
         @(posedge clk); #1;
         latSeen++;
      end
   endtask

   task automatic finishResponse();
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      checkOutput("resp_valid after ack", {31'b0, bus.resp_valid}, 32'd0);
      checkOutput("req_ready after ack", {31'b0, bus.req_ready}, 32'd1);
   endtask

   initial begin
      logic sawValid;

      bus.req_valid  = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_cin    = 1'b0;
      bus.req_op     = 4'h0;
      bus.resp_ready = 1'b0;

      //          a        b        cin   op       res      cout  ovf   zero  err   lat cinVec
      vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 4'b0000, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0110};
      vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4, 4'b1110};
      vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 4'b0000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 4, 4'b1110};
      vecs[3]  = '{16'hF0F0, 16'hFF00, 1'b0, 4'b1010, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0000};
      vecs[4]  = '{16'h1234, 16'h5678, 1'b1, 4'b0101, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 0, 4'b0000};
      vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 4'b0000, 16'h5556, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0001};
      vecs[6]  = '{16'h0005, 16'h0003, 1'b1, 4'b0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 4, 4'b1111};
      vecs[7]  = '{16'hABCD, 16'h0F0F, 1'b1, 4'b1000, 16'h0B0D, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4'b0000};
      vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 4'b0110, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 0, 4'b0000};
      vecs[9]  = '{16'h8000, 16'h8000, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 4, 4'b0000};
      vecs[10] = '{16'h4321, 16'h0000, 1'b0, 4'b0111, 16'h8642, 1'b0, 1'b1, 1'b0, 1'b0, 4, 4'b0000};

      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset req_ready", {31'b0, bus.req_ready}, 32'd1);
      checkOutput("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      checkOutput("reset resp_result", {16'b0, bus.resp_result}, 32'd0);
      checkOutput("reset resp_zero", {31'b0, bus.resp_zero}, 32'd0);
      checkOutput("reset resp_err", {31'b0, bus.resp_err}, 32'd0);
      checkOutput("reset alu bus", {19'b0, aluA, aluB, aluCin, aluS}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op);
         checkOutput($sformatf("v%0d latency", i), latSeen, vecs[i].lat);
         checkOutput($sformatf("v%0d result", i), {16'b0, bus.resp_result}, {16'b0, vecs[i].res});
         checkOutput($sformatf("v%0d cout", i), {31'b0, bus.resp_cout}, {31'b0, vecs[i].cout});
         checkOutput($sformatf("v%0d ovf", i), {31'b0, bus.resp_ovf}, {31'b0, vecs[i].ovf});
         checkOutput($sformatf("v%0d zero", i), {31'b0, bus.resp_zero}, {31'b0, vecs[i].zero});
         checkOutput($sformatf("v%0d err", i), {31'b0, bus.resp_err}, {31'b0, vecs[i].err});
         checkOutput($sformatf("v%0d alu_cin per nibble", i), {28'b0, cinSeen}, {28'b0, vecs[i].cinVec});
         checkOutput($sformatf("v%0d alu_s during run", i), {31'b0, sBad}, 32'd0);
         checkOutput($sformatf("v%0d alu bus in done", i), {19'b0, aluA, aluB, aluCin, aluS}, 32'd0);
         checkOutput($sformatf("v%0d req_ready in done", i), {31'b0, bus.req_ready}, 32'd0);
         finishResponse();
      end

      // Backpressure: response must hold while a competing request is offered and ignored.
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 4'b0000);
      bus.req_a     = 16'hFFFF;
      bus.req_op    = 4'b0101;
      bus.req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("hold%0d resp_valid", k), {31'b0, bus.resp_valid}, 32'd1);
         checkOutput($sformatf("hold%0d result", k), {16'b0, bus.resp_result}, 32'h0100);
         checkOutput($sformatf("hold%0d err", k), {31'b0, bus.resp_err}, 32'd0);
         checkOutput($sformatf("hold%0d req_ready", k), {31'b0, bus.req_ready}, 32'd0);
      end
      bus.req_valid = 1'b0;
      finishResponse();
      @(posedge clk); #1;
      checkOutput("ignored request not taken", {31'b0, bus.resp_valid}, 32'd0);

      // Reset while the third nibble is on the ALU.
      bus.req_a     = 16'h5678;
      bus.req_b     = 16'h1111;
      bus.req_cin   = 1'b0;
      bus.req_op    = 4'b0000;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("idx2 alu_a", {28'b0, aluA}, 32'h6);
      checkOutput("idx2 alu_b", {28'b0, aluB}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort req_ready", {31'b0, bus.req_ready}, 32'd1);
      checkOutput("abort resp_valid", {31'b0, bus.resp_valid}, 32'd0);
      checkOutput("abort alu bus", {19'b0, aluA, aluB, aluCin, aluS}, 32'd0);
      checkOutput("abort resp_result", {16'b0, bus.resp_result}, 32'd0);
      sawValid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) sawValid = 1'b1;
      end
      checkOutput("no response after abort", {31'b0, sawValid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
